// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the multiply/divide sequencer.
// Optional divide support is controlled by the MDU_DIV_EN macro (see mdu_seq).
package mdu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic       MDU_MULTU = 1'b0;
   localparam logic       MDU_DIVU  = 1'b1;

   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;

   localparam int         STEPS     = 32;

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one shift-add (MULTU) or restoring-divide (DIVU) bit step.
// Pure combinational: drives the shared ALU and forms the next {hi, lo}.
// Carry/borrow is recovered from the ALU result by comparison, so no adder
// lives here. The divide path exists only when MDU_DIV_EN is defined.
module mdu_step
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             i_run,
`ifdef MDU_DIV_EN
   input  logic             i_op,
`endif
   input  logic [WIDTH-1:0] i_hi,
   input  logic [WIDTH-1:0] i_lo,
   input  logic [WIDTH-1:0] i_m,
   input  logic [WIDTH-1:0] i_alu_result,
   output logic [WIDTH-1:0] o_alu_a,
   output logic [WIDTH-1:0] o_alu_b,
   output logic [3:0]       o_alu_ctrl,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   logic             w_c;
`ifdef MDU_DIV_EN
   logic [WIDTH-1:0] w_s;
   logic             w_nb;
`endif

   // ALU drive and next-state of the hi/lo pair for the current step
   always_comb begin
      o_alu_a    = '0;
      o_alu_b    = '0;
      o_alu_ctrl = ALU_ADD;
      o_hi       = i_hi;
      o_lo       = i_lo;
      w_c        = 1'b0;
`ifdef MDU_DIV_EN
      w_s        = {i_hi[WIDTH-2:0], i_lo[WIDTH-1]};
      w_nb       = 1'b0;
`endif
      if (i_run) begin
`ifdef MDU_DIV_EN
         if (i_op == MDU_DIVU) begin
            // trial subtract of the shifted partial remainder; the bit
            // shifted out of hi means s >= 2^WIDTH > M, so never a borrow
            o_alu_a    = w_s;
            o_alu_b    = i_m;
            o_alu_ctrl = ALU_SUB;
            w_nb       = i_hi[WIDTH-1] | (i_alu_result <= w_s);
            if (w_nb) begin
               o_hi = i_alu_result;
               o_lo = {i_lo[WIDTH-2:0], 1'b1};
            end else begin
               o_hi = w_s;
               o_lo = {i_lo[WIDTH-2:0], 1'b0};
            end
         end else
`endif
         begin
            // add multiplicand when the current multiplier bit is set,
            // then shift {carry, sum, lo} right by one
            o_alu_a    = i_hi;
            o_alu_b    = i_lo[0] ? i_m : '0;
            o_alu_ctrl = ALU_ADD;
            w_c        = (i_alu_result < i_hi);
            o_hi       = {w_c, i_alu_result[WIDTH-1:1]};
            o_lo       = {i_alu_result[0], i_lo[WIDTH-1:1]};
         end
      end
   end

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: iterative 32-step MULTU/DIVU sequencer for the HI/LO unit,
// time-sharing the external ALU. Define MDU_DIV_EN to include DIVU;
// without it, a DIVU request is silently ignored.
module mdu_seq
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_result
);

   localparam int CW = $clog2(STEPS);

   state_t           r_state, w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_hi, r_lo, r_m;
   logic             r_busy;
   logic             w_accept;
   logic             w_run;
   logic [WIDTH-1:0] w_hi_nxt, w_lo_nxt;
`ifdef MDU_DIV_EN
   logic             r_op;
`endif

   assign w_run = (r_state == RUN);

   mdu_step #(.WIDTH(WIDTH)) u_step (
      .i_run        (w_run),
`ifdef MDU_DIV_EN
      .i_op         (r_op),
`endif
      .i_hi         (r_hi),
      .i_lo         (r_lo),
      .i_m          (r_m),
      .i_alu_result (alu_result),
      .o_alu_a      (alu_a),
      .o_alu_b      (alu_b),
      .o_alu_ctrl   (alu_ctrl),
      .o_hi         (w_hi_nxt),
      .o_lo         (w_lo_nxt)
   );

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // next state and accept decode
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
`ifdef MDU_DIV_EN
            w_accept = start;
`else
            w_accept = start & (op == MDU_MULTU);
`endif
            if (w_accept) w_state_nxt = RUN;
         end
         RUN:     if (r_cnt == CW'(STEPS-1)) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // operand capture on accept, one bit step per RUN cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hi  <= '0;
         r_lo  <= '0;
         r_m   <= '0;
         r_cnt <= '0;
`ifdef MDU_DIV_EN
         r_op  <= MDU_MULTU;
`endif
      end else if (w_accept) begin
         r_hi  <= '0;
         r_lo  <= (op == MDU_DIVU) ? src_a : src_b;
         r_m   <= (op == MDU_DIVU) ? src_b : src_a;
         r_cnt <= '0;
`ifdef MDU_DIV_EN
         r_op  <= op;
`endif
      end else if (w_run) begin
         r_hi  <= w_hi_nxt;
         r_lo  <= w_lo_nxt;
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // busy: set by accept, cleared on leaving DONE
   always_ff @(posedge clk) begin
      if (!rst_n)                r_busy <= 1'b0;
      else if (w_accept)         r_busy <= 1'b1;
      else if (r_state == DONE)  r_busy <= 1'b0;
   end

   assign busy = r_busy;
   assign done = (r_state == DONE);
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed + random checks of mdu_seq against an arithmetic
// reference (a*b, a/b, a%b) with a behavioural ALU attached.
module tb_mdu_seq;

   logic        clk = 1'b0;
   logic        rst_n, start, op;
   logic [31:0] src_a, src_b;
   logic        busy, done;
   logic [31:0] hi, lo, alu_a, alu_b, alu_result;
   logic [3:0]  alu_ctrl;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // external shared ALU
   assign alu_result = (alu_ctrl == 4'b0110) ? (alu_a - alu_b) : (alu_a + alu_b);

   mdu_seq #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
      .hi(hi), .lo(lo), .alu_a(alu_a), .alu_b(alu_b),
      .alu_ctrl(alu_ctrl), .alu_result(alu_result)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // {hi, lo} expected from the architectural definition
   function automatic logic [63:0] model(input bit o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      if (!o) begin
         p = {32'd0, a} * {32'd0, b};
         return p;
      end
      if (b == 32'd0) return {a, 32'hFFFFFFFF};
      return {a % b, a / b};
   endfunction

   // run one op from a negedge; optionally pulse start at RUN cycle poke_at
   // and/or in the DONE cycle; returns at a negedge in IDLE
   task automatic do_op(input string tag, input bit o, input logic [31:0] a,
                        input logic [31:0] b, input int poke_at, input bit poke_done);
      logic [63:0] exp;
      int lat;
      exp   = model(o, a, b);
      start = 1'b1; op = o; src_a = a; src_b = b;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         start = (i == poke_at);
         if (i == poke_at) begin src_a = ~a; src_b = b + 32'd9; end
         if (done) begin
            lat = i;
            start = poke_done;
            break;
         end
      end
      chk({tag, ".lat"}, 64'(lat), 64'd33);
      chk({tag, ".busy_done"}, 64'(busy), 64'd1);
      chk({tag, ".hilo"}, {hi, lo}, exp);
      @(negedge clk);
      start = 1'b0;
      chk({tag, ".busy_after"}, 64'(busy), 64'd0);
      chk({tag, ".done_pulse"}, 64'(done), 64'd0);
      chk({tag, ".hold"}, {hi, lo}, exp);
   endtask

   initial begin
      int seen;
      logic [31:0] ra, rb;
      logic [63:0] prev;
      rst_n = 1'b0; start = 1'b0; op = 1'b0; src_a = '0; src_b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst.busy", 64'(busy), 64'd0);
      chk("rst.done", 64'(done), 64'd0);
      chk("rst.hilo", {hi, lo}, 64'd0);
      chk("idle.alu", {alu_a, alu_b, 28'd0, alu_ctrl}, {32'd0, 32'd0, 28'd0, 4'b0010});

      do_op("mul7x6", 1'b0, 32'd7, 32'd6, 0, 1'b0);
      do_op("mulmax", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
      chk("mulmax.hi", 64'(hi), 64'hFFFFFFFE);
      do_op("mulbusy", 1'b0, 32'd3, 32'd5, 10, 1'b1);
      chk("mulbusy.lo", 64'(lo), 64'd15);
      chk("idle.alu2", {alu_a, alu_b, 28'd0, alu_ctrl}, {32'd0, 32'd0, 28'd0, 4'b0010});

`ifdef MDU_DIV_EN
      do_op("div100_7", 1'b1, 32'd100, 32'd7, 0, 1'b0);
      do_op("divmax_1", 1'b1, 32'hFFFFFFFF, 32'd1, 0, 1'b0);
      do_op("div0", 1'b1, 32'h12345678, 32'd0, 0, 1'b0);
      do_op("divbusy", 1'b1, 32'd1000, 32'd33, 5, 1'b1);
`else
      // DIVU request must leave the block untouched
      prev  = {hi, lo};
      start = 1'b1; op = 1'b1; src_a = 32'd100; src_b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy || done) seen++;
      end
      chk("divoff.activity", 64'(seen), 64'd0);
      chk("divoff.hilo", {hi, lo}, prev);
`endif

      // abort in flight with reset
      start = 1'b1;
`ifdef MDU_DIV_EN
      op = 1'b1;
`else
      op = 1'b0;
`endif
      src_a = 32'd5000; src_b = 32'd17;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort.busy", 64'(busy), 64'd0);
      chk("abort.done", 64'(done), 64'd0);
      chk("abort.hilo", {hi, lo}, 64'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      chk("abort.nodone", 64'(seen), 64'd0);
      do_op("mul2x3", 1'b0, 32'd2, 32'd3, 0, 1'b0);

      // random operations against the reference
      for (int n = 0; n < 8; n++) begin
         ra = $urandom;
         rb = (n == 3) ? 32'd0 : ((n % 3 == 0) ? ($urandom & 32'hFF) : $urandom);
`ifdef MDU_DIV_EN
         do_op("rand", n[0], ra, rb, 0, 1'b0);
`else
         do_op("rand", 1'b0, ra, rb, 0, 1'b0);
`endif
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Iterative multiply/divide sequencer for the MIPS core's HI/LO unit. It runs unsigned 32×32 multiply (MULTU) and unsigned 32÷32 divide (DIVU) as 32 one-bit steps. Each step drives the shared 32-bit ALU (ADD 4'b0010, SUB 4'b0110) through its operand and control ports. The ALU itself is instantiated outside this block and time-shared with the EX stage.

## Interface
Parameters:
- `WIDTH`, 32: operand width; fixed to the ALU width, not intended to change.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  1  0 = MULTU, 1 = DIVU.
- `src_a`  in  32  multiplicand, or dividend.
- `src_b`  in  32  multiplier, or divisor.
- `busy`  out  1  high from the cycle after accept through the DONE cycle inclusive.
- `done`  out  1  one-cycle pulse when `hi`/`lo` become valid.
- `hi`  out  32  product[63:32], or remainder.
- `lo`  out  32  product[31:0], or quotient.
- `alu_a`  out  32  ALU operand A.
- `alu_b`  out  32  ALU operand B.
- `alu_ctrl`  out  4  ALU control code.
- `alu_result`  in  32  ALU result; combinational return, same cycle.

## Operation
- **States:** IDLE → RUN → DONE → IDLE.
- **Accept:** in IDLE with `start`=1, capture the operands.
  - Multiply: `hi`=0, `lo`=src_b, operand register M=src_a.
  - Divide: `hi`=0, `lo`=src_a, M=src_b.
  - Clear the 5-bit step counter and go to RUN.
- **Multiply step (RUN, op=0):**
  - Drive `alu_a`=hi, `alu_b`= lo[0] ? M : 0, `alu_ctrl`=ADD.
  - Carry c = (alu_result < hi), unsigned.
  - Update {hi, lo} ← {c, alu_result, lo[31:1]}.
- **Divide step (RUN, op=1):**
  - Form s = {hi[30:0], lo[31]} and t = hi[31].
  - Drive `alu_a`=s, `alu_b`=M, `alu_ctrl`=SUB.
  - No-borrow condition nb = t | (alu_result <= s).
  - If nb: hi←alu_result, lo←{lo[30:0],1}. Else: hi←s, lo←{lo[30:0],0}.
- **Step count:** the counter increments each RUN cycle. After the step with counter=31, go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- **Result hold:** `hi`/`lo` hold their value from DONE until the next accept.
- **Carry/borrow source:** derived from `alu_result` only; the block contains no adder or subtractor of its own.
- **ALU drive outside RUN:** `alu_a`=0, `alu_b`=0, `alu_ctrl`=ADD.
- **Divide by zero:** not trapped. Result is `lo`=32'hFFFFFFFF, `hi`=dividend.
- **Start while busy:** `start` in RUN or DONE is ignored; it is not queued.

## Timing
- **Reset:** `rst_n`=0 at a clock edge forces IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0. This applies mid-operation too: the operation in flight is aborted and no `done` is produced.
- **Latency:** with `start` accepted at edge k, RUN occupies edges k+1..k+32 (32 steps) and DONE is the state after edge k+32. `done` is high for the cycle between edges k+32 and k+33.
- **Throughput:** the earliest next accept is at edge k+34, i.e. 34 cycles per operation.
- **ALU path:** `alu_a`/`alu_b`/`alu_ctrl` are combinational from state, and `alu_result` is consumed in the same cycle. The single-cycle path is the ALU plus this block's compare and register setup.
- **`busy`:** registered, and deasserts in the IDLE cycle following DONE.

## Configuration
- **`MDU_DIV_EN` defined:** DIVU is supported as described above.
- **`MDU_DIV_EN` undefined:**
  - The divide step logic and the SUB drive are compiled out.
  - `start` with `op`=1 is ignored: no state change, no `busy`, no `done`, `hi`/`lo` unchanged.
  - MULTU behaviour and timing are identical to the enabled build.

## Structure
- **Package `mdu_pkg`:**
  - state enum (IDLE, RUN, DONE);
  - op encodings MDU_MULTU=1'b0, MDU_DIVU=1'b1;
  - ALU codes ALU_ADD=4'b0010, ALU_SUB=4'b0110;
  - STEPS=32.
- **Sub-module `mdu_step`:** combinational. It computes the ALU drive and the next {hi, lo} from (op, hi, lo, M, alu_result). `mdu_seq` keeps the FSM, counter and registers.

## Test plan
- **Small multiply:** MULTU 7×6 → `done` exactly 33 edges after the accepting edge; `hi`=0, `lo`=42; `busy` low the cycle after.
- **Multiply carry:** MULTU 32'hFFFFFFFF×32'hFFFFFFFF → `hi`=32'hFFFFFFFE, `lo`=32'h00000001.
- **Basic divide:** DIVU 100÷7 → `lo`=14, `hi`=2. DIVU 32'hFFFFFFFF÷1 → `lo`=32'hFFFFFFFF, `hi`=0.
- **Divide by zero:** DIVU 32'h12345678÷0 → `lo`=32'hFFFFFFFF, `hi`=32'h12345678; no hang, normal latency.
- **Start while busy:** `start` pulsed at step 10 of a MULTU 3×5 with different operands → ignored; result `lo`=15. Also drive `start` during the DONE cycle → ignored.
- **Reset mid-operation:** `rst_n` low for one edge at step 20 of a DIVU → next cycle IDLE, `busy`=0, `hi`=`lo`=0, no `done`. A subsequent MULTU 2×3 gives `lo`=6.
